// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

  localparam int unsigned ESR_W = 4;

  localparam logic [ESR_W-1:0] ESR_NONE  = 4'b0000;
  localparam logic [ESR_W-1:0] ESR_IRQ   = 4'b0001;
  localparam logic [ESR_W-1:0] ESR_UNDEF = 4'b0010;

  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'hD8;

endpackage

// File: rtl/exc_flush_cnt.sv
// Down-counter timing the pipeline flush window; done marks the last flush cycle.
module exc_flush_cnt #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES) + 1;

  logic [CW-1:0] cnt;

  // Loaded with FLUSH_CYCLES-1 so that zero coincides with the final flush cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer: captures ELR/ESR, flushes, redirects to the handler
// and back on ERET. Build option EXC_LATCH_IRQ_EN keeps ExtIRQ seen outside RUN pending.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned  N            = 64,
  parameter logic [N-1:0] EXC_VECTOR   = N'(EXC_VECTOR_DEFAULT),
  parameter int unsigned  FLUSH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic             NotAnInstr,
  input  logic [ESR_W-1:0] EStatus,
  input  logic             ERet,
  input  logic             ExtIRQ,
  input  logic [N-1:0]     PC_dec,
  output logic             Flush,
  output logic             Redirect,
  output logic [N-1:0]     RedirectPC,
  output logic [N-1:0]     ELR,
  output logic [ESR_W-1:0] ESR,
  output logic             InHandler,
  output logic             DFault
);

  exc_state_t       state, state_nxt;
  logic [N-1:0]     elr_nxt;
  logic [ESR_W-1:0] esr_nxt;
  logic             dfault_nxt;
  logic             cnt_load;
  logic             flush_done;
  logic             take_undef;
  logic             irq_req;

  assign take_undef = InstrValid && NotAnInstr;

`ifdef EXC_LATCH_IRQ_EN
  logic irq_pending, irq_pending_nxt;

  assign irq_req = ExtIRQ || irq_pending;

  // Hold any IRQ that cannot be taken now; a taken IRQ clears it.
  always_comb begin
    irq_pending_nxt = 1'b0;
    if ((state != RUN) || take_undef) begin
      irq_pending_nxt = irq_pending || ExtIRQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending <= 1'b0;
    end else begin
      irq_pending <= irq_pending_nxt;
    end
  end
`else
  assign irq_req = ExtIRQ;
`endif

  exc_flush_cnt #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (state == FLUSH),
    .done_c(flush_done)
  );

  // Next state, register updates, and the Moore/Mealy redirect outputs.
  always_comb begin
    state_nxt  = state;
    elr_nxt    = ELR;
    esr_nxt    = ESR;
    dfault_nxt = DFault;
    cnt_load   = 1'b0;
    Flush      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;

    case (state)
      RUN: begin
        if (take_undef) begin
          elr_nxt   = PC_dec;
          esr_nxt   = EStatus;
          cnt_load  = 1'b1;
          state_nxt = FLUSH;
        end else if (irq_req) begin
          elr_nxt   = PC_dec;
          esr_nxt   = ESR_IRQ;
          cnt_load  = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        Flush = 1'b1;
        if (flush_done) begin
          Redirect   = 1'b1;
          RedirectPC = EXC_VECTOR;
          state_nxt  = HANDLER;
        end
      end
      HANDLER: begin
        if (InstrValid && ERet) begin
          Flush      = 1'b1;
          Redirect   = 1'b1;
          RedirectPC = ELR;
          esr_nxt    = ESR_NONE;
          state_nxt  = RUN;
        end else if (take_undef) begin
          dfault_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ELR       <= '0;
      ESR       <= ESR_NONE;
      DFault    <= 1'b0;
      InHandler <= 1'b0;
    end else begin
      state     <= state_nxt;
      ELR       <= elr_nxt;
      ESR       <= esr_nxt;
      DFault    <= dfault_nxt;
      InHandler <= (state_nxt == HANDLER);
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed vector table, a hand sequence, and random traffic
// checked against a counting reference model.
module tb_exception_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned FC = 3;
  localparam logic [63:0] VEC = 64'hD8;

  logic        clk = 1'b0;
  logic        reset, iv, nai, eret, irq;
  logic [3:0]  est;
  logic [63:0] pc;
  logic        flush, redir, inh, dflt;
  logic [63:0] rpc, elr;
  logic [3:0]  esr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .InstrValid(iv),
    .NotAnInstr(nai),
    .EStatus   (est),
    .ERet      (eret),
    .ExtIRQ    (irq),
    .PC_dec    (pc),
    .Flush     (flush),
    .Redirect  (redir),
    .RedirectPC(rpc),
    .ELR       (elr),
    .ESR       (esr),
    .InHandler (inh),
    .DFault    (dflt)
  );

  typedef struct {
    logic        chk;
    logic        rst, iv, nai, eret, irq;
    logic [3:0]  est;
    logic [63:0] pc;
    logic        flush, redir;
    logic [63:0] rpc, elr;
    logic [3:0]  esr;
    logic        inh, dflt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: flush countdown, handler flag and architectural registers.
  int          m_left;
  bit          m_hnd, m_df, m_pend;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic chk, input logic r, input logic v, input logic n,
                              input logic e, input logic q, input logic [3:0] s,
                              input logic [63:0] p, input logic f, input logic rd,
                              input logic [63:0] rp, input logic [63:0] el,
                              input logic [3:0] es, input logic h, input logic d);
    vec_t t;
    t.chk = chk; t.rst = r; t.iv = v; t.nai = n; t.eret = e; t.irq = q; t.est = s; t.pc = p;
    t.flush = f; t.redir = rd; t.rpc = rp; t.elr = el; t.esr = es; t.inh = h; t.dflt = d;
    return t;
  endfunction

  task automatic drive(input logic r, input logic v, input logic n, input logic e,
                       input logic q, input logic [3:0] s, input logic [63:0] p);
    reset = r; iv = v; nai = n; eret = e; irq = q; est = s; pc = p;
  endtask

  task automatic model_reset();
    m_left = 0; m_hnd = 0; m_df = 0; m_pend = 0; m_elr = '0; m_esr = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit latch;
`ifdef EXC_LATCH_IRQ_EN
    latch = 1'b1;
`else
    latch = 1'b0;
`endif
    if (reset) begin
      model_reset();
    end else if (m_left > 0) begin
      if (latch && irq) m_pend = 1;
      m_left--;
      if (m_left == 0) m_hnd = 1;
    end else if (m_hnd) begin
      if (latch && irq) m_pend = 1;
      if (iv && eret) begin
        m_hnd = 0; m_esr = 4'b0000;
      end else if (iv && nai) begin
        m_df = 1;
      end
    end else if (iv && nai) begin
      m_elr = pc; m_esr = est; m_left = FC;
      if (latch && irq) m_pend = 1;
    end else if (irq || m_pend) begin
      m_elr = pc; m_esr = 4'b0001; m_left = FC; m_pend = 0;
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then step the model.
  task automatic step(input bit check, input logic r, input logic v, input logic n,
                      input logic e, input logic q, input logic [3:0] s, input logic [63:0] p);
    logic        ef, er;
    logic [63:0] erp;
    @(negedge clk);
    drive(r, v, n, e, q, s, p);
    #2;
    ef = 0; er = 0; erp = '0;
    if (m_left > 0) begin
      ef = 1; er = (m_left == 1); erp = er ? VEC : 64'd0;
    end else if (m_hnd && iv && eret) begin
      ef = 1; er = 1; erp = m_elr;
    end
    if (check) begin
      cmp("Flush", 64'(flush), 64'(ef));
      cmp("Redirect", 64'(redir), 64'(er));
      cmp("RedirectPC", rpc, erp);
      cmp("ELR", elr, m_elr);
      cmp("ESR", 64'(esr), 64'(m_esr));
      cmp("InHandler", 64'(inh), 64'(m_hnd));
      cmp("DFault", 64'(dflt), 64'(m_df));
    end
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    logic [63:0] e22_elr;
    logic [3:0]  e22_esr;
    logic        e22_f;
    drive(1, 0, 0, 0, 0, 4'h0, 64'h0);
    repeat (2) @(posedge clk);

`ifdef EXC_LATCH_IRQ_EN
    e22_f = 1; e22_elr = 64'hA0; e22_esr = 4'b0001;
`else
    e22_f = 0; e22_elr = 64'h90; e22_esr = 4'b0000;
`endif
    //          chk r iv na er iq est   pc       fl rd rpc      elr      esr h  df
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 4'h2, 64'h40, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h40, 4'h2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h40, 4'h2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 1, 64'hD8, 64'h40, 4'h2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h40, 4'h2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 4'h2, 64'h44, 0, 0, 64'h00, 64'h40, 4'h2, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h40, 4'h2, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1, 0, 4'h2, 64'h48, 1, 1, 64'h40, 64'h40, 4'h2, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h40, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 1, 4'h2, 64'h80, 0, 0, 64'h00, 64'h40, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'h0, 64'h00, 1, 0, 64'h00, 64'h80, 4'h2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'h0, 64'h00, 1, 0, 64'h00, 64'h80, 4'h2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'h0, 64'h00, 1, 1, 64'hD8, 64'h80, 4'h2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 4'h0, 64'h00, 1, 1, 64'h80, 64'h80, 4'h2, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'h0, 64'h90, 0, 0, 64'h00, 64'h80, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h90, 4'h1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h90, 4'h1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 1, 64'hD8, 64'h90, 4'h1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'h0, 64'h00, 0, 0, 64'h00, 64'h90, 4'h1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 4'h0, 64'h00, 1, 1, 64'h90, 64'h90, 4'h1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'hA0, 0, 0, 64'h00, 64'h90, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, e22_f, 0, 64'h00, e22_elr, e22_esr, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 4'h2, 64'h40, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h40, 4'h2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4'h0, 64'h00, 1, 0, 64'h00, 64'h40, 4'h2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 64'h00, 0, 0, 64'h00, 64'h00, 4'h0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].nai, tbl[i].eret, tbl[i].irq, tbl[i].est, tbl[i].pc);
      #2;
      if (tbl[i].chk) begin
        cmp($sformatf("row%0d.Flush", i), 64'(flush), 64'(tbl[i].flush));
        cmp($sformatf("row%0d.Redirect", i), 64'(redir), 64'(tbl[i].redir));
        cmp($sformatf("row%0d.RedirectPC", i), rpc, tbl[i].rpc);
        cmp($sformatf("row%0d.ELR", i), elr, tbl[i].elr);
        cmp($sformatf("row%0d.ESR", i), 64'(esr), 64'(tbl[i].esr));
        cmp($sformatf("row%0d.InHandler", i), 64'(inh), 64'(tbl[i].inh));
        cmp($sformatf("row%0d.DFault", i), 64'(dflt), 64'(tbl[i].dflt));
      end
      @(posedge clk);
    end

    // Hand sequence: synchronise the model, then entry with an arbitrary cause right after ERET.
    step(0, 1, 0, 0, 0, 0, 4'h0, 64'h0);
    step(1, 0, 1, 1, 0, 0, 4'h2, 64'h100);
    repeat (FC + 1) step(1, 0, 0, 0, 0, 0, 4'h0, 64'h0);
    step(1, 0, 1, 0, 1, 0, 4'h0, 64'h0);
    step(1, 0, 1, 1, 0, 0, 4'hA, 64'h1230);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4'h0, 64'h0);
    #2;
    cmp("b2b.ELR", elr, 64'h1230);
    cmp("b2b.ESR", 64'(esr), 64'hA);
    cmp("b2b.Flush", 64'(flush), 64'h1);
    @(posedge clk);
    model_edge();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), 4'($urandom),
           {$urandom, $urandom} & ~64'h3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
